// File: rtl/fxp_dot_sequencer_if.sv
// Request/result and memory-read bundle for the fixed-point dot-product sequencer.
// The slave side is the sequencer; the master side is the requester plus x/w memories.
interface fxp_dot_sequencer_if #(
    parameter int ADDR_W = 6
);
    logic              i_start;
    logic [ADDR_W:0]   i_len;
    logic [23:0]       i_bias;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_addr;
    logic [15:0]       i_x;
    logic [15:0]       i_w;
    logic              o_busy;
    logic [23:0]       o_result;
    logic              o_valid;
    logic              o_ovf;

    modport master (
        output i_start, i_len, i_bias, i_x, i_w,
        input  o_rd_en, o_addr, o_busy, o_result, o_valid, o_ovf
    );

    modport slave (
        input  i_start, i_len, i_bias, i_x, i_w,
        output o_rd_en, o_addr, o_busy, o_result, o_valid, o_ovf
    );
endinterface

// File: rtl/fxp_dot_sequencer.sv
// Per-neuron MAC controller: bias + sum(x[k]*w[k]) over one shared Q8.8
// multiplier, with a saturated Q16.8 result.
module fxp_dot_sequencer #(
    parameter int N_MAX  = 64,
    parameter int ADDR_W = 6,
    parameter int ACC_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    fxp_dot_sequencer_if.slave        bus
);
    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } state_t;

    localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(N_MAX);

    state_t                   state;
    state_t                   state_nxt;
    logic [ADDR_W:0]          len_q;
    logic [ADDR_W:0]          len_clamp;
    logic [ADDR_W-1:0]        addr_q;
    logic                     drain_q;
    logic                     rd_en;
    logic                     busy;
    logic                     last_addr;
    logic                     start_ok;
    logic                     rd_d1;
    logic                     rd_d2;
    logic signed [31:0]       prod_q;
    logic signed [ACC_W-1:0]  acc_q;
    logic                     sat_hi;
    logic                     sat_lo;
    logic [23:0]              result_q;
    logic                     ovf_q;
    logic                     valid_q;

    assign len_clamp = (bus.i_len > LEN_MAX) ? LEN_MAX : bus.i_len;
    assign start_ok  = (state == IDLE) && bus.i_start;
    assign last_addr = ({1'b0, addr_q} == (len_q - (ADDR_W+1)'(1)));

    // Overflow iff the accumulator bits above the Q16.8 sign bit disagree with it.
    assign sat_hi = !acc_q[ACC_W-1] && (|acc_q[ACC_W-2:23]);
    assign sat_lo =  acc_q[ACC_W-1] && !(&acc_q[ACC_W-2:23]);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-state strobes.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_nxt = (len_clamp == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                rd_en = 1'b1;
                busy  = 1'b1;
                if (last_addr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_q) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Length latch, address counter and two-cycle drain timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q   <= '0;
            addr_q  <= '0;
            drain_q <= 1'b0;
        end else begin
            if (start_ok) begin
                len_q <= len_clamp;
                if (len_clamp != '0) begin
                    addr_q <= '0;
                end
            end else if (state == READ && !last_addr) begin
                addr_q <= addr_q + ADDR_W'(1);
            end
            drain_q <= (state == DRAIN) ? !drain_q : 1'b0;
        end
    end

    // Multiply/accumulate pipeline: product one cycle after the read, add one later.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_d1  <= 1'b0;
            rd_d2  <= 1'b0;
            prod_q <= '0;
            acc_q  <= '0;
        end else begin
            rd_d1 <= rd_en;
            rd_d2 <= rd_d1;
            if (rd_d1) begin
                prod_q <= $signed(bus.i_x) * $signed(bus.i_w);
            end
            if (start_ok) begin
                acc_q <= {{(ACC_W-24){bus.i_bias[23]}}, bus.i_bias};
            end else if (rd_d2) begin
                acc_q <= acc_q + ACC_W'(prod_q >>> 8);
            end
        end
    end

    // Saturate and publish the result at the end of DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            ovf_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= (state == DONE);
            if (state == DONE) begin
                ovf_q <= sat_hi || sat_lo;
                if (sat_hi) begin
                    result_q <= 24'h7FFFFF;
                end else if (sat_lo) begin
                    result_q <= 24'h800000;
                end else begin
                    result_q <= acc_q[23:0];
                end
            end
        end
    end

    assign bus.o_rd_en  = rd_en;
    assign bus.o_addr   = addr_q;
    assign bus.o_busy   = busy;
    assign bus.o_result = result_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_ovf    = ovf_q;

endmodule

// File: tb/tb_fxp_dot_sequencer.sv
// Scoreboard bench for fxp_dot_sequencer: a reference model predicts each
// result, its o_valid cycle and its read count; a monitor checks them.
module tb_fxp_dot_sequencer;
    localparam int N_MAX  = 64;
    localparam int ADDR_W = 6;

    typedef struct {
        logic [23:0] res;
        logic        ovf;
        int          len;
        int          vcyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    exp_t        sb[$];
    logic [15:0] xm[N_MAX];
    logic [15:0] wm[N_MAX];
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          rdidx = 0;

    always #5 clk = ~clk;

    fxp_dot_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    fxp_dot_sequencer #(
        .N_MAX (N_MAX),
        .ADDR_W(ADDR_W),
        .ACC_W (32)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic exp_t model(int len, logic [23:0] bias, int c0);
        exp_t   e;
        int     l;
        longint acc;
        longint p;
        l   = (len > N_MAX) ? N_MAX : len;
        acc = longint'($signed(bias));
        for (int k = 0; k < l; k++) begin
            p   = longint'($signed(xm[k])) * longint'($signed(wm[k]));
            acc = acc + (p >>> 8);
        end
        if (acc > 64'sd8388607) begin
            e.res = 24'h7FFFFF;
            e.ovf = 1'b1;
        end else if (acc < -64'sd8388608) begin
            e.res = 24'h800000;
            e.ovf = 1'b1;
        end else begin
            e.res = acc[23:0];
            e.ovf = 1'b0;
        end
        e.len  = l;
        e.vcyc = c0 + l + 4;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Synchronous-read x/w memories.
    always @(posedge clk) begin
        if (bus.o_rd_en) begin
            bus.i_x <= xm[bus.o_addr];
            bus.i_w <= wm[bus.o_addr];
        end
    end

    // Monitor: address sequence and result pops.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.o_rd_en) begin
                chk("addr", 32'(bus.o_addr), 32'(rdidx));
                rdidx++;
            end
            if (bus.o_valid) begin
                if (sb.size() == 0) begin
                    chk("spurious_valid", 32'(bus.o_valid), 32'(0));
                end else begin
                    e = sb.pop_front();
                    chk("result", 32'(bus.o_result), 32'(e.res));
                    chk("ovf", 32'(bus.o_ovf), 32'(e.ovf));
                    chk("valid_cyc", 32'(cyc), 32'(e.vcyc));
                    chk("rd_count", 32'(rdidx), 32'(e.len));
                    chk("busy_low", 32'(bus.o_busy), 32'(0));
                end
                rdidx = 0;
            end
        end
    end

    task automatic start_op(int len, logic [23:0] bias);
        bus.i_start = 1'b1;
        bus.i_len   = 7'(len);
        bus.i_bias  = bias;
        sb.push_back(model(len, bias, cyc));
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        bus.i_len   = 7'($urandom);
        bus.i_bias  = 24'($urandom);
    endtask

    task automatic wait_done();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            chk("timeout", 32'(sb.size()), 32'(0));
            sb.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_rd_en"}, 32'(bus.o_rd_en), 32'(0));
        chk({tag, "_addr"}, 32'(bus.o_addr), 32'(0));
        chk({tag, "_busy"}, 32'(bus.o_busy), 32'(0));
        chk({tag, "_valid"}, 32'(bus.o_valid), 32'(0));
        chk({tag, "_ovf"}, 32'(bus.o_ovf), 32'(0));
        chk({tag, "_result"}, 32'(bus.o_result), 32'(0));
    endtask

    task automatic fill_rand(int n);
        for (int k = 0; k < n; k++) begin
            xm[k] = 16'($urandom);
            wm[k] = 16'($urandom);
        end
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        bus.i_start = 1'b0;
        bus.i_len   = '0;
        bus.i_bias  = '0;
        for (int k = 0; k < N_MAX; k++) begin
            xm[k] = '0;
            wm[k] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single term, negative product rounds toward -inf.
        xm[0] = 16'hAA5A;
        wm[0] = 16'h4AF0;
        start_op(1, 24'h000000);
        wait_done();

        // Three-term accumulate with bias.
        xm[0] = 16'h0100; wm[0] = 16'h0200;
        xm[1] = 16'h0100; wm[1] = 16'hFF00;
        xm[2] = 16'h0100; wm[2] = 16'h0080;
        start_op(3, 24'h000040);
        wait_done();

        // Positive then negative saturation.
        for (int k = 0; k < 4; k++) begin
            xm[k] = 16'h7FFF;
            wm[k] = 16'h7FFF;
        end
        start_op(4, 24'h000000);
        wait_done();
        for (int k = 0; k < 3; k++) begin
            xm[k] = 16'h8000;
            wm[k] = 16'h7FFF;
        end
        start_op(3, 24'h000000);
        wait_done();

        // Zero length, then clamp of an oversize length.
        start_op(0, 24'h000180);
        wait_done();
        fill_rand(N_MAX);
        start_op(100, 24'($urandom));
        wait_done();

        // Start while busy is ignored; start in the valid cycle is taken.
        fill_rand(3);
        start_op(3, 24'($urandom));
        @(posedge clk);
        #1;
        bus.i_start = 1'b1;
        bus.i_len   = 7'd5;
        chk("busy_mid", 32'(bus.o_busy), 32'(1));
        @(posedge clk);
        #1;
        bus.i_start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.o_valid && n < 50);
        chk("valid_seen", 32'(bus.o_valid), 32'(1));
        fill_rand(2);
        start_op(2, 24'($urandom));
        chk("b2b_rd_en", 32'(bus.o_rd_en), 32'(1));
        wait_done();

        // Reset mid-operation aborts with no result.
        fill_rand(8);
        start_op(8, 24'($urandom));
        @(posedge clk);
        #1;
        rst = 1'b1;
        sb.delete();
        rdidx = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk_zero("abort");
        repeat (20) @(negedge clk);
        @(posedge clk);
        #1;
        xm[0] = 16'hF380;
        wm[0] = 16'h0321;
        start_op(1, 24'h001234);
        wait_done();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
